// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified IF/MEM RAM port: state encoding,
// default bus widths and requester identifiers.
package mips_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arb_state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/mem_grant_sel.sv
// Combinational grant decision: MEM has priority, but once IF has lost
// MAX_STARVE contended rounds in a row it is forced in.
module mem_grant_sel #(
    parameter int MAX_STARVE = 3,
    parameter int SW         = 2
) (
    input  logic          if_req,
    input  logic          mem_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_if,
    output logic          grant_mem,
    output logic [SW-1:0] starve_nxt
);

    logic starved;

    assign starved = (starve_cnt >= SW'(MAX_STARVE));

    always_comb begin
        grant_mem  = mem_req && (!if_req || !starved);
        grant_if   = if_req && !grant_mem;
        starve_nxt = starve_cnt;
        if (grant_if)
            starve_nxt = '0;
        // only a contended MEM win counts against IF; it can never pass MAX_STARVE
        else if (grant_mem && if_req)
            starve_nxt = starve_cnt + SW'(1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported unified RAM shared by IF (fetch) and MEM (load/store):
// one access at a time, WAIT_STATES+1 RAM cycles, registered data + ready pulse.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int WAIT_STATES = 1,
    parameter int MAX_STARVE  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          gnt_mem
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int SW = $clog2(MAX_STARVE + 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          grant_if, grant_mem;
    logic          gnt_id;
    logic          done;

    mem_grant_sel #(.MAX_STARVE(MAX_STARVE), .SW(SW)) u_sel (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .starve_cnt (starve_cnt),
        .grant_if   (grant_if),
        .grant_mem  (grant_mem),
        .starve_nxt (starve_nxt)
    );

    assign gnt_id  = grant_mem ? REQ_MEM : REQ_IF;
    assign done    = (state != IDLE) && (cnt == '0);
    assign busy    = (state != IDLE);
    assign gnt_mem = (state == BUSY_MEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mem)     state_nxt = BUSY_MEM;
                else if (grant_if) state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_MEM: if (done) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // RAM controls are registered so they stay glitch-free for the whole access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            starve_cnt <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (state == IDLE) begin
                starve_cnt <= starve_nxt;
                if (grant_if || grant_mem) begin
                    ram_en    <= 1'b1;
                    ram_we    <= (gnt_id == REQ_MEM) ? mem_we : 1'b0;
                    ram_addr  <= (gnt_id == REQ_MEM) ? mem_addr : if_addr;
                    ram_wdata <= (gnt_id == REQ_MEM) ? mem_wdata : '0;
                    cnt       <= CW'(WAIT_STATES);
                end
            end else if (done) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                if (state == BUSY_MEM) begin
                    mem_ready <= 1'b1;
                    if (!ram_we) mem_rdata <= ram_rdata;
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= ram_rdata;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model of the
// expected RAM/ready timing checked every cycle on the falling edge.
module tb_mem_port_arbiter;

    localparam int WS  = 1;
    localparam int MS  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, mem_ready, ram_en, ram_we, busy, gnt_mem;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(WS), .MAX_STARVE(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .gnt_mem(gnt_mem)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0040_0000)      return 32'h2010_000A;
        else if (a == 32'h1001_0000) return 32'h1234_5678;
        else                         return a ^ 32'hA5A5_A5A5;
    endfunction

    always_comb ram_rdata = rom(ram_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---- model: one access record (who, start cycle, latched fields) ----
    int          cyc, a_start, a_who, m_starve;
    bit          a_vld, a_we;
    logic [31:0] a_addr, a_wd, m_if_rd, m_mem_rd;
    int          gq[$];

    always @(negedge clk) begin
        bit act, rdy, idle;
        if (!rst_n) begin
            cyc = 0; a_vld = 0; a_we = 0; a_who = 0; a_start = 0;
            a_addr = '0; a_wd = '0; m_starve = 0; m_if_rd = '0; m_mem_rd = '0;
        end
        act  = a_vld && cyc >= a_start && cyc <= a_start + WS;
        rdy  = a_vld && cyc == a_start + WS + 1;
        idle = !a_vld || cyc >= a_start + WS + 1;
        chk("ram_en",    ram_en,    act);
        chk("ram_we",    ram_we,    act && a_we);
        chk("ram_addr",  ram_addr,  a_addr);
        chk("ram_wdata", ram_wdata, a_wd);
        chk("if_ready",  if_ready,  rdy && a_who == 1);
        chk("mem_ready", mem_ready, rdy && a_who == 2);
        chk("busy",      busy,      act);
        chk("gnt_mem",   gnt_mem,   act && a_who == 2);
        chk("if_rdata",  if_rdata,  m_if_rd);
        chk("mem_rdata", mem_rdata, m_mem_rd);
        if (rst_n) begin
            if (act && cyc == a_start + WS && !a_we) begin
                if (a_who == 1) m_if_rd = ram_rdata;
                else            m_mem_rd = ram_rdata;
            end
            if (idle) begin
                if (mem_req && (!if_req || m_starve < MS)) begin
                    if (if_req) m_starve++;
                    a_vld = 1; a_who = 2; a_start = cyc + 1;
                    a_we = mem_we; a_addr = mem_addr; a_wd = mem_wdata;
                    gq.push_back(2);
                end else if (if_req) begin
                    m_starve = 0;
                    a_vld = 1; a_who = 1; a_start = cyc + 1;
                    a_we = 0; a_addr = if_addr; a_wd = '0;
                    gq.push_back(1);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for a ready pulse (sel 1 = IF, 2 = MEM); n = cycles taken, en = ram_en cycles
    task automatic wait_ready(input int sel, output int n, output int en);
        n = 0; en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ram_en) en++;
            if ((sel == 1 && if_ready) || (sel == 2 && mem_ready)) return;
        end
        chk("ready_timeout", 0, 1);
    endtask

    initial begin
        int n, en, pulses;
        bit seen_if;
        rst_n = 0; if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        tick(); tick();
        chk("reset_ram_en", ram_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_if_rdata", if_rdata, 0);
        rst_n = 1;
        tick();

        // 1: single fetch
        if_addr = 32'h0040_0000; if_req = 1;
        wait_ready(1, n, en);
        if_req = 0;
        chk("fetch_latency", n, 3);
        chk("fetch_en_cycles", en, 2);
        chk("fetch_data", if_rdata, 32'h2010_000A);
        tick();

        // 2: contention, MEM first then IF
        if_addr = 32'h0040_0004; mem_addr = 32'h1001_0000; mem_we = 0;
        if_req = 1; mem_req = 1;
        wait_ready(2, n, en);
        mem_req = 0;
        chk("cont_mem_latency", n, 3);
        chk("cont_mem_data", mem_rdata, 32'h1234_5678);
        wait_ready(1, n, en);
        if_req = 0;
        chk("cont_if_latency", n, 3);
        chk("cont_if_data", if_rdata, 32'hA5E5_A5A1);
        tick();

        // 3: starvation, both held high
        gq.delete();
        seen_if = 0;
        if_req = 1; mem_req = 1;
        for (int i = 0; i < 60 && gq.size() < 5; i++) begin
            tick();
            if (busy && !gnt_mem && !seen_if) begin
                seen_if = 1;
                chk("starve_cleared", dut.starve_cnt, 0);
            end
        end
        if_req = 0; mem_req = 0;
        chk("starve_grants", gq.size(), 5);
        if (gq.size() >= 5) begin
            chk("starve_g0", gq[0], 2);
            chk("starve_g1", gq[1], 2);
            chk("starve_g2", gq[2], 2);
            chk("starve_g3", gq[3], 1);
            chk("starve_g4", gq[4], 2);
        end
        for (int i = 0; i < 5; i++) tick();

        // 4: store
        mem_we = 1; mem_addr = 32'h1001_0004; mem_wdata = 32'hDEAD_BEEF; mem_req = 1;
        tick();
        chk("store_we", ram_we, 1);
        chk("store_addr", ram_addr, 32'h1001_0004);
        chk("store_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        chk("store_we2", ram_we, 1);
        tick();
        chk("store_ready", mem_ready, 1);
        chk("store_we_drop", ram_we, 0);
        mem_req = 0; mem_we = 0;
        chk("store_rdata_kept", mem_rdata, 32'h1234_5678);
        tick();

        // 5: reset mid-access
        mem_addr = 32'h1001_0000; mem_req = 1;
        tick();
        chk("rst_pre_gnt", gnt_mem, 1);
        rst_n = 0;
        #1;
        chk("rst_async_en", ram_en, 0);
        chk("rst_async_busy", busy, 0);
        mem_req = 0;
        tick(); tick();
        chk("rst_mem_rdata", mem_rdata, 0);
        rst_n = 1;
        tick();
        mem_req = 1;
        wait_ready(2, n, en);
        mem_req = 0;
        chk("rst_after_latency", n, 3);
        chk("rst_after_data", mem_rdata, 32'h1234_5678);
        tick();

        // 6: request withdrawn one cycle after grant
        mem_addr = 32'h1001_0008; mem_req = 1;
        tick();
        tick();
        mem_req = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ready) pulses++;
        end
        chk("withdraw_pulses", pulses, 1);
        chk("withdraw_data", mem_rdata, 32'hB5A4_A5AD);
        chk("withdraw_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
